pararam_wb_master: RTL and testbench

//   Wishbone classic single-transfer master (initiator): the opposite end of the user-area

---
 rtl/pararam_wb_master.sv | 158 +++++++++++++++
 tb/tb_pararam_wb_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pararam_wb_master.sv
// Wishbone classic single-transfer master: turns a valid/ready command into one
// read or write cycle and returns data or a timeout error on a valid/ready response.
module pararam_wb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_adr_i,
  input  logic [DATA_W-1:0]   cmd_dat_i,
  input  logic [DATA_W/8-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  output logic                busy_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TERM_CNT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_e;

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              cyc_q,       cyc_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] adr_q,       adr_d;
  logic [DATA_W-1:0] dat_q,       dat_d;
  logic [SEL_W-1:0]  sel_q,       sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_dat_q,   rsp_dat_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              busy_q,      busy_d;
  logic              cmd_ready_q, cmd_ready_d;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready_q is the registered image of IDLE, so it also blocks the first post-reset edge.
        if (cmd_valid_i && cmd_ready_q) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == TERM_CNT)) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_pararam_wb_master.sv
// Self-checking bench for pararam_wb_master: directed transfers plus random ones,
// each checked against the expected outcome derived from the slave's wait count.
module tb_pararam_wb_master;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack;
  logic [31:0] wbm_dat_i;
  logic        busy;

  int checks = 0;
  int errors = 0;

  pararam_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_sel_o   (wbm_sel),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_i   (wbm_ack),
    .wbm_dat_i   (wbm_dat_i),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer against a slave that acks after wait_n wait cycles,
  // followed by bp cycles of response backpressure with stray acks and commands.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int wait_n, input logic [31:0] rdata,
                      input int bp);
    int          guard;
    int          ncyc;
    int          exp_ncyc;
    logic        exp_err;
    logic [31:0] exp_dat;
    exp_err  = (wait_n >= TO);
    exp_dat  = (we || exp_err) ? 32'h0 : rdata;
    exp_ncyc = exp_err ? TO : wait_n + 1;

    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    guard     = 0;
    while (!cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("cmd_ready_before_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_we    = ~we;
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
    cmd_sel   = 4'($urandom);

    ncyc = 0;
    while (wbm_cyc && ncyc < 50) begin
      check("stb_eq_cyc", wbm_stb, 1);
      check("bus_we", wbm_we, we);
      check("bus_adr", wbm_adr, adr);
      check("bus_dat", wbm_dat_o, dat);
      check("bus_sel", wbm_sel, sel);
      check("rsp_valid_in_bus", rsp_valid, 0);
      check("busy_in_bus", busy, 1);
      wbm_ack   = (ncyc == wait_n);
      wbm_dat_i = wbm_ack ? rdata : $urandom;
      ncyc++;
      tick();
      wbm_ack = 1'b0;
    end
    check("cyc_cycles", 64'(ncyc), 64'(exp_ncyc));
    check("cyc_dropped", {wbm_cyc, wbm_stb}, 2'b00);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_dat", rsp_dat, exp_dat);
    check("rsp_err", rsp_err, exp_err);
    check("cmd_ready_in_resp", cmd_ready, 0);

    for (int i = 0; i < bp; i++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'($urandom);
      wbm_ack   = 1'($urandom);
      wbm_dat_i = $urandom;
      tick();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_dat", rsp_dat, exp_dat);
      check("bp_rsp_err", rsp_err, exp_err);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_cyc", wbm_cyc, 0);
    end
    wbm_ack   = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_taken", rsp_valid, 0);
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_cyc", wbm_cyc, 0);
  endtask

  initial begin
    int          wait_n;
    int          bp;
    logic [31:0] rdata;

    // Reset with random inputs: every output held at zero.
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'($urandom);
      cmd_we    = 1'($urandom);
      cmd_adr   = $urandom;
      cmd_dat   = $urandom;
      cmd_sel   = 4'($urandom);
      rsp_ready = 1'($urandom);
      wbm_ack   = 1'($urandom);
      wbm_dat_i = $urandom;
      tick();
      check("reset_outputs",
            {32'h0, cmd_ready, rsp_valid, rsp_err, wbm_cyc, wbm_stb, wbm_we, busy, wbm_sel},
            64'h0);
      check("reset_rsp_dat", rsp_dat, 0);
      check("reset_adr_dat", {wbm_adr, wbm_dat_o}, 0);
    end
    cmd_valid = 1'b0;
    wbm_ack   = 1'b0;
    rsp_ready = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("ready_at_release", cmd_ready, 0);
    tick();
    check("ready_after_release", cmd_ready, 1);
    check("busy_after_release", busy, 0);

    // Write with two wait cycles, read with zero wait.
    xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 2, 32'hA5A5_A5A5, 0);
    xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 32'h1234_5678, 0);

    // Timeout with no ack, then ack arriving on the terminal cycle.
    xfer(1'b0, 32'h3000_0008, 32'h0, 4'h3, 99, 32'hCAFE_F00D, 0);
    xfer(1'b0, 32'h3000_000C, 32'h0, 4'hC, TO - 1, 32'hCAFE_F00D, 0);

    // Backpressure on the response channel.
    xfer(1'b0, 32'h3000_0020, 32'h0, 4'h1, 1, 32'h0BAD_F00D, 5);

    // Random transfers.
    for (int n = 0; n < 24; n++) begin
      wait_n = int'($urandom_range(0, TO + 1));
      bp     = int'($urandom_range(0, 3));
      rdata  = $urandom;
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), wait_n, rdata, bp);
    end

    // Reset during an active bus cycle.
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_0040;
    cmd_sel   = 4'hF;
    tick();
    cmd_valid = 1'b0;
    check("midop_cyc_up", wbm_cyc, 1);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("midop_cyc_drop", {wbm_cyc, wbm_stb}, 2'b00);
    check("midop_busy", busy, 0);
    check("midop_rsp_valid", rsp_valid, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wbm_ack   = 1'($urandom);
      wbm_dat_i = $urandom;
      rsp_ready = 1'($urandom);
      tick();
      check("post_reset_no_rsp", rsp_valid, 0);
      check("post_reset_no_cyc", wbm_cyc, 0);
    end
    wbm_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
